// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, state encoding and byte-merge helper for if_fetch
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int BYTE_W      = 8;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DONE  = 1'b1
  } fetch_state_t;

  // Drop one returned byte into its little-endian lane of the word being assembled.
  function automatic logic [INST_W-1:0] merge_byte(input logic [INST_W-1:0] word,
                                                   input logic [1:0]        idx,
                                                   input logic [BYTE_W-1:0] b);
    logic [INST_W-1:0] r;
    r = word;
    r[8*idx +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// rtl/if_fetch_icache.sv - direct-mapped instruction cache, one 32-bit word per line
// Ports:
//   clk, rst   clock; synchronous active-high reset clears all valid bits
//   pc_word    word address of the PC (pc[31:2]) used for lookup and fill
//   hit        line at pc_word's index is valid and its tag matches
//   hit_line   word stored at pc_word's index
//   fill_en    write fill_line and the tag of pc_word, set the line valid
//   fill_line  assembled instruction to store
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INST_ADDR_W-1:2]   pc_word,
  output logic                     hit,
  output logic [INST_W-1:0]        hit_line,
  input  logic                     fill_en,
  input  logic [INST_W-1:0]        fill_line
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [INST_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;

  assign idx      = pc_word[2 +: IDX_W];
  assign tag      = pc_word[INST_ADDR_W-1 : 2+IDX_W];
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  assign hit_line = data_mem[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Storage needs no reset: a line is never read as a hit until its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_mem[idx] <= fill_line;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: owns the PC, reads 4 bytes per instruction, presents it to decode
// Optional I-cache: define IF_ICACHE_EN.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall_in           decode not ready, hold the presented instruction
//   mem_busy           memory controller serves the mem stage this cycle; IF address ignored
//   jump_en, jump_addr redirect PC (highest priority after rst)
//   addr_to_memctrl    byte address of the IF read
//   data_from_memctrl  byte read data, one cycle after its address
//   inst_valid         inst/inst_pc valid
//   inst, inst_pc      assembled little-endian instruction and its address
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0,
  parameter int unsigned            ICACHE_LINES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_in,
  input  logic                   mem_busy,
  input  logic                   jump_en,
  input  logic [INST_ADDR_W-1:0] jump_addr,
  output logic [INST_ADDR_W-1:0] addr_to_memctrl,
  input  logic [BYTE_W-1:0]      data_from_memctrl,
  output logic                   inst_valid,
  output logic [INST_W-1:0]      inst,
  output logic [INST_ADDR_W-1:0] inst_pc
);

  fetch_state_t           state_q, state_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]             cnt_q, cnt_d;          // bytes issued, 0..4
  logic                   pend_valid_q, pend_valid_d;
  logic [1:0]             pend_idx_q, pend_idx_d;
  logic [INST_W-1:0]      buf_q, buf_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic [INST_ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_W-1:0]      captured;

`ifdef IF_ICACHE_EN
  logic              cache_hit;
  logic [INST_W-1:0] cache_line;
  logic              fill_en;

  if_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .pc_word  (pc_q[INST_ADDR_W-1:2]),
    .hit      (cache_hit),
    .hit_line (cache_line),
    .fill_en  (fill_en),
    .fill_line(captured)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      cnt_q        <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= 2'd0;
      buf_q        <= ZERO_WORD;
      inst_q       <= ZERO_WORD;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      buf_q        <= buf_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    cnt_d           = cnt_q;
    pend_valid_d    = 1'b0;
    pend_idx_d      = pend_idx_q;
    buf_d           = buf_q;
    inst_d          = inst_q;
    inst_pc_d       = inst_pc_q;
    captured        = merge_byte(buf_q, pend_idx_q, data_from_memctrl);
    addr_to_memctrl = pc_q;
`ifdef IF_ICACHE_EN
    fill_en         = 1'b0;
`endif

    case (state_q)
      ST_FETCH: begin
        addr_to_memctrl = pc_q + {29'd0, cnt_q};
        // Byte addressed last cycle arrives now; the last lane completes the instruction.
        if (pend_valid_q) begin
          buf_d = captured;
          if (pend_idx_q == 2'd3) begin
            inst_d    = captured;
            inst_pc_d = pc_q;
            state_d   = ST_DONE;
`ifdef IF_ICACHE_EN
            fill_en   = 1'b1;
`endif
          end
        end
        // A busy cycle means the controller ignored our address: reissue the same byte.
        if (!cnt_q[2] && !mem_busy) begin
          pend_valid_d = 1'b1;
          pend_idx_d   = cnt_q[1:0];
          cnt_d        = cnt_q + 3'd1;
        end
`ifdef IF_ICACHE_EN
        // Hit on FETCH entry replaces the whole byte sequence.
        if (cnt_q == 3'd0 && cache_hit) begin
          inst_d       = cache_line;
          inst_pc_d    = pc_q;
          state_d      = ST_DONE;
          pend_valid_d = 1'b0;
          cnt_d        = cnt_q;
        end
`endif
      end
      ST_DONE: begin
        if (!stall_in) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = 3'd0;
          buf_d   = ZERO_WORD;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    // Redirect discards everything in flight, including a byte returning next cycle.
    if (jump_en) begin
      pc_d         = jump_addr;
      cnt_d        = 3'd0;
      pend_valid_d = 1'b0;
      buf_d        = ZERO_WORD;
      state_d      = ST_FETCH;
`ifdef IF_ICACHE_EN
      fill_en      = 1'b0;
`endif
    end
  end

  assign inst_valid = (state_q == ST_DONE);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch (vector table, directed corners, random vs reference model)
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          LINES    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        mem_busy;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] addr_to_memctrl;
  logic [7:0]  data_from_memctrl;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic [7:0]  ram [4096];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC    (RESET_PC),
    .ICACHE_LINES(LINES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_in         (stall_in),
    .mem_busy         (mem_busy),
    .jump_en          (jump_en),
    .jump_addr        (jump_addr),
    .addr_to_memctrl  (addr_to_memctrl),
    .data_from_memctrl(data_from_memctrl),
    .inst_valid       (inst_valid),
    .inst             (inst),
    .inst_pc          (inst_pc)
  );

  // Memory controller: one-cycle latency; while busy it returns mem-stage garbage.
  always @(posedge clk) begin
    if (mem_busy) data_from_memctrl <= 8'($urandom);
    else          data_from_memctrl <= ram[addr_to_memctrl[11:0]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_in = 1'b0; mem_busy = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!inst_valid && n < max_cycles) begin
      step();
      n++;
    end
    chk({name, " wait"}, 32'(inst_valid), 32'd1);
  endtask

  // Reference model state: current fetch PC, bytes issued, presenting flag, cache prediction.
  logic [31:0] m_pc;
  int          m_issued;
  bit          m_present;
  bit          m_hit;
`ifdef IF_ICACHE_EN
  logic [29:0] m_cache [int];

  function automatic int cache_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'(LINES - 1));
  endfunction
`endif

  task automatic new_fetch();
    m_issued  = 0;
    m_present = 1'b0;
    m_hit     = 1'b0;
`ifdef IF_ICACHE_EN
    if (m_cache.exists(cache_idx(m_pc)) && m_cache[cache_idx(m_pc)] == m_pc[31:2]) m_hit = 1'b1;
`endif
  endtask

  typedef struct {
    logic        busy;
    logic        stall;
    logic        v;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl [18];
  int   reads;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'(i * 7 + 3);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
    ram[4] = 8'h93; ram[5] = 8'h05; ram[6] = 8'h10; ram[7] = 8'h00;
    ram[256] = 8'hEF; ram[257] = 8'hBE; ram[258] = 8'hAD; ram[259] = 8'hDE;

    // Cycle-by-cycle: inst at 0 stalled 3 cycles, then inst at 4 with mem_busy during byte-1 issue.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h1, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h2, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h3, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h4, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h00A00513, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h00A00513, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h00A00513, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h00A00513, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h4, 32'h0,        32'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h5, 32'h0,        32'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'h5, 32'h0,        32'h0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h5, 32'h0,        32'h0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h6, 32'h0,        32'h0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h7, 32'h0,        32'h0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h8, 32'h0,        32'h0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 32'h4, 32'h00100593, 32'h4};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h8, 32'h0,        32'h0};

    @(negedge clk);
    do_reset();
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset addr", addr_to_memctrl, RESET_PC);
    chk("reset inst", inst, 32'h0);
    chk("reset inst_pc", inst_pc, 32'h0);

    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tbl[%0d] inst_valid", i), 32'(inst_valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d] addr", i), addr_to_memctrl, tbl[i].addr);
      if (tbl[i].v) begin
        chk($sformatf("tbl[%0d] inst", i), inst, tbl[i].inst);
        chk($sformatf("tbl[%0d] inst_pc", i), inst_pc, tbl[i].ipc);
      end
      mem_busy = tbl[i].busy;
      stall_in = tbl[i].stall;
      step();
    end

    // Jump while issue_cnt=2, then reset while issue_cnt=3 of the following fetch.
    do_reset();
    step();
    step();
    chk("jump pre addr", addr_to_memctrl, 32'h2);
    jump_en = 1'b1; jump_addr = 32'h100;
    step();
    jump_en = 1'b0;
    chk("jump addr", addr_to_memctrl, 32'h100);
    chk("jump inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    chk("jump early valid", 32'(inst_valid), 32'd0);
    step();
    chk("jump valid", 32'(inst_valid), 32'd1);
    chk("jump inst", inst, 32'hDEADBEEF);
    chk("jump inst_pc", inst_pc, 32'h100);
    for (int i = 0; i < 4; i++) step();
    chk("pre-rst addr", addr_to_memctrl, 32'h107);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst addr", addr_to_memctrl, RESET_PC);
    chk("midrst inst", inst, 32'h0);
    chk("midrst inst_pc", inst_pc, 32'h0);

`ifdef IF_ICACHE_EN
    // Two-instruction loop: first pass fills, second pass must hit.
    do_reset();
    wait_valid("ic inst0", 10);
    chk("ic inst0", inst, 32'h00A00513);
    step();
    wait_valid("ic inst1", 12);
    chk("ic inst1", inst, 32'h00100593);
    jump_en = 1'b1; jump_addr = 32'h0;
    step();
    jump_en = 1'b0;
    reads = 0;
    chk("ic hit0 fetch valid", 32'(inst_valid), 32'd0);
    chk("ic hit0 addr", addr_to_memctrl, 32'h0);
    if (addr_to_memctrl[1:0] != 2'b00) reads++;
    step();
    chk("ic hit0 valid", 32'(inst_valid), 32'd1);
    chk("ic hit0 inst", inst, 32'h00A00513);
    chk("ic hit0 inst_pc", inst_pc, 32'h0);
    step();
    chk("ic hit1 fetch valid", 32'(inst_valid), 32'd0);
    if (addr_to_memctrl[1:0] != 2'b00) reads++;
    step();
    chk("ic hit1 valid", 32'(inst_valid), 32'd1);
    chk("ic hit1 inst", inst, 32'h00100593);
    chk("ic hit1 inst_pc", inst_pc, 32'h4);
    chk("ic byte reads", 32'(reads), 32'd0);
`endif

    // Random busy/stall/jump traffic against the reference model.
    do_reset();
    m_pc = RESET_PC;
`ifdef IF_ICACHE_EN
    m_cache.delete();
`endif
    new_fetch();
    for (int c = 0; c < 1500; c++) begin
      chk("rnd inst_valid", 32'(inst_valid), 32'(m_present));
      if (m_present) begin
        chk("rnd inst", inst, word_at(m_pc));
        chk("rnd inst_pc", inst_pc, m_pc);
        chk("rnd done addr", addr_to_memctrl, m_pc);
      end else begin
        chk("rnd fetch addr", addr_to_memctrl, m_pc + 32'(m_issued));
      end
      mem_busy = ($urandom_range(3) == 0);
      stall_in = ($urandom_range(2) == 0);
      jump_en  = ($urandom_range(31) == 0);
      if ($urandom_range(1) == 0) jump_addr = {24'd0, 2'($urandom_range(3)), 6'd0};
      else                        jump_addr = {20'd0, 10'($urandom_range(1023)), 2'b00};
      if (jump_en) begin
        m_pc = jump_addr;
        new_fetch();
      end else if (m_present) begin
        if (!stall_in) begin
          m_pc = m_pc + 32'd4;
          new_fetch();
        end
      end else if (m_hit) begin
        m_present = 1'b1;
      end else if (m_issued == 4) begin
        m_present = 1'b1;
`ifdef IF_ICACHE_EN
        m_cache[cache_idx(m_pc)] = m_pc[31:2];
`endif
      end else if (!mem_busy) begin
        m_issued++;
      end
      step();
    end
    jump_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
